// File: rtl/fifo_byte_unpacker_pkg.sv
// fifo_byte_unpacker_pkg
//   Shared definitions for the word-to-byte unpacker: byte width and the
//   2-bit encoding of the control FSM states.
package fifo_byte_unpacker_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_SEND  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        LOAD  = ST_LOAD,
        SEND  = ST_SEND
    } state_t;

endpackage

// File: rtl/fifo_byte_unpacker.sv
// fifo_byte_unpacker
//   Pops no_bits-wide words from an upstream FIFO and streams them out one
//   byte at a time over a valid/ready handshake.
//
//   Parameters
//     no_bits    word width of the FIFO (multiple of 8, at least 16)
//     lsb_first  1: byte [7:0] goes out first; 0: top byte goes out first
//
//   Ports
//     clk         clock, all state on the rising edge
//     reset       asynchronous active-low reset
//     en          allows a new word fetch to start
//     fifo_empty  upstream FIFO empty flag
//     fifo_d_out  upstream FIFO read data (valid the cycle after the pop)
//     fifo_cs     FIFO chip select, high only in the pop cycle
//     fifo_rd_en  FIFO pop strobe
//     byte_out    byte presented downstream
//     byte_valid  byte_out is valid
//     byte_ready  downstream accepts byte_out this cycle
//     byte_last   byte_out is the final byte of the word
//     busy        FSM is not idle
module fifo_byte_unpacker
    import fifo_byte_unpacker_pkg::*;
#(
    parameter int no_bits   = 32,
    parameter int lsb_first = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               fifo_empty,
    input  logic [no_bits-1:0] fifo_d_out,
    output logic               fifo_cs,
    output logic               fifo_rd_en,
    output logic [BYTE_W-1:0]  byte_out,
    output logic               byte_valid,
    input  logic               byte_ready,
    output logic               byte_last,
    output logic               busy
);

    localparam int              N        = no_bits / BYTE_W;
    localparam int              IDX_W    = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t             r_state;
    logic [no_bits-1:0] r_word;
    logic [IDX_W-1:0]   r_idx;

    logic               w_start;
    logic               w_at_last;
    logic [IDX_W-1:0]   w_sel;
    logic [BYTE_W-1:0]  w_bytes [N];

    assign w_start   = en && !fifo_empty;
    assign w_at_last = (r_idx == LAST_IDX);

    // Control FSM, word register and byte index. The word is captured in
    // LOAD because the FIFO presents its data one cycle after the pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_word  <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    r_state <= LOAD;
                end
                LOAD: begin
                    r_word  <= fifo_d_out;
                    r_idx   <= '0;
                    r_state <= SEND;
                end
                SEND: begin
                    if (byte_ready) begin
                        if (w_at_last) begin
                            // Chain straight into the next word when possible
                            // so back-to-back words cost N+2 cycles each.
                            r_state <= w_start ? FETCH : IDLE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Slice the word register into bytes once; the output mux indexes this.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_bytes
            assign w_bytes[gi] = r_word[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    // Reversing the index rather than the word keeps a single mux for both
    // byte orders.
    assign w_sel = (lsb_first != 0) ? r_idx : (LAST_IDX - r_idx);

    // All outputs decode from registered state only; reset zeroes the state,
    // word and index, so every output reads 0 while reset is held.
    assign byte_out   = w_bytes[w_sel];
    assign byte_valid = (r_state == SEND);
    assign byte_last  = (r_state == SEND) && w_at_last;
    assign fifo_cs    = (r_state == FETCH);
    assign fifo_rd_en = (r_state == FETCH);
    assign busy       = (r_state != IDLE);

endmodule
